// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the pipe-3 calculation-unit dispatcher.
`default_nettype none

package alu_pkg;

    localparam int ALU_CALC_WIDTH = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } dispatch_state_t;

    // Opcode value doubles as the index of the unit that executes it.
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: request, unit and result buses between pipe 2, the calculation units and writeback.
`default_nettype none

interface alu_dispatch_if
    import alu_pkg::*;
#(
    parameter int CALCULATION_WIDTH = ALU_CALC_WIDTH,
    parameter int NUM_UNITS         = 4,
    parameter int OPCODE_WIDTH      = 2
);

    logic                                   req_valid;
    logic                                   req_ready;
    logic [OPCODE_WIDTH-1:0]                req_op;
    logic [CALCULATION_WIDTH-1:0]           req_a;
    logic [CALCULATION_WIDTH-1:0]           req_b;

    logic [CALCULATION_WIDTH-1:0]           unit_a;
    logic [CALCULATION_WIDTH-1:0]           unit_b;
    logic [NUM_UNITS-1:0]                   unit_start_n;
    logic [NUM_UNITS-1:0]                   unit_rdy;
    logic [NUM_UNITS*CALCULATION_WIDTH-1:0] unit_result;

    logic                                   res_valid;
    logic                                   res_ready;
    logic [CALCULATION_WIDTH-1:0]           res_data;
    logic                                   res_error;

    // Environment side: pipe 2, the calculation units and writeback.
    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  unit_a, unit_b, unit_start_n,
        output unit_rdy, unit_result,
        input  res_valid, res_data, res_error,
        output res_ready
    );

    // Dispatcher side.
    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output unit_a, unit_b, unit_start_n,
        input  unit_rdy, unit_result,
        output res_valid, res_data, res_error,
        input  res_ready
    );

endinterface

`default_nettype wire

// File: rtl/alu_dispatch_timer.sv
// alu_dispatch_timer: clearable saturating cycle counter that flags when LIMIT-1 is reached.
`default_nettype none

module alu_dispatch_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/alu_dispatch.sv
// alu_dispatch: issues one ALU request to the selected multi-cycle unit, waits for rdy and
// hands the captured result (or an illegal-opcode / timeout error) to writeback.
`default_nettype none

module alu_dispatch
    import alu_pkg::*;
#(
    parameter int CALCULATION_WIDTH = ALU_CALC_WIDTH,
    parameter int NUM_UNITS         = 4,
    parameter int OPCODE_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic          clk,
    input  logic          rst,
    alu_dispatch_if.slave bus
);

    dispatch_state_t                state_q, state_d;
    logic [OPCODE_WIDTH-1:0]        op_q, op_d;
    logic [CALCULATION_WIDTH-1:0]   a_q, a_d;
    logic [CALCULATION_WIDTH-1:0]   b_q, b_d;
    logic [NUM_UNITS-1:0]           start_n_q, start_n_d;
    logic                           res_valid_q, res_valid_d;
    logic [CALCULATION_WIDTH-1:0]   res_data_q, res_data_d;
    logic                           res_error_q, res_error_d;

    logic                           op_legal;
    logic                           sel_rdy;
    logic [CALCULATION_WIDTH-1:0]   sel_result;
    logic                           tmr_clear;
    logic                           tmr_inc;
    logic                           tmr_expired;

    assign op_legal = (32'(bus.req_op) < NUM_UNITS);

    // Only the unit that was launched is observed; everything else on the unit bus is ignored.
    always_comb begin
        sel_rdy    = 1'b0;
        sel_result = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (32'(op_q) == i) begin
                sel_rdy    = bus.unit_rdy[i];
                sel_result = bus.unit_result[i*CALCULATION_WIDTH +: CALCULATION_WIDTH];
            end
        end
    end

    alu_dispatch_timer #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        start_n_d   = '1;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;
        tmr_clear   = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    a_d  = bus.req_a;
                    b_d  = bus.req_b;
                    if (op_legal) begin
                        state_d = LAUNCH;
                        // Registered so the pulse covers exactly the LAUNCH cycle.
                        for (int i = 0; i < NUM_UNITS; i++) begin
                            start_n_d[i] = (32'(bus.req_op) != i);
                        end
                    end else begin
                        state_d     = RESPOND;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_error_d = 1'b1;
                    end
                end
            end

            LAUNCH: begin
                state_d   = WAIT;
                tmr_clear = 1'b1;
            end

            WAIT: begin
                if (sel_rdy) begin
                    state_d     = RESPOND;
                    res_valid_d = 1'b1;
                    res_data_d  = sel_result;
                    res_error_d = 1'b0;
                end else if (tmr_expired) begin
                    state_d     = RESPOND;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_error_d = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            RESPOND: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            start_n_q   <= '1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            start_n_q   <= start_n_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE) & rst;
    assign bus.unit_a       = a_q;
    assign bus.unit_b       = b_q;
    assign bus.unit_start_n = start_n_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_error    = res_error_q;

endmodule

`default_nettype wire
